uart_packet_tx: RTL and testbench

Parametrised UART packet transmitter. It is the successor to the fixed 22-byte header+payload sender and is used to stream sensor/status records from the FPGA to the PC.
- Latches an N-byte payload on a start request.
- Prepends a configurable header and optionally appends an 8-bit additive checksum.
- Serialises the packet as 8N1/8N2 UART with an internal 32-bit phase-accumulator baud generator at 16x oversampling.
- Reports busy/done and flags start requests that arrive while it is busy.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_packet_tx_if.sv | 24 ++
 rtl/uart_byte_tx.sv | 122 ++++++++++++
 rtl/uart_packet_tx.sv | 153 +++++++++++++++
 tb/tb_uart_packet_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet transmitter.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        PKT_IDLE,
        PKT_HDR,
        PKT_PAY,
        PKT_CHK,
        PKT_FIN
    } pkt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Accumulator increment for a given clock and baud, rounded to nearest:
    // 2^32 * baud * OVERSAMPLE / clk_hz.
    function automatic logic [31:0] calc_devide_cnt(input longint unsigned clk_hz,
                                                    input longint unsigned baud);
        longint unsigned num;
        num = (baud * 64'(OVERSAMPLE)) << 32;
        return 32'((num + clk_hz / 2) / clk_hz);
    endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Request/status bundle between a packet source and the UART packet transmitter.
// Latency: n/a (wiring only).
// Backpressure: none; sources watch busy, starts while busy are reported via start_drop.
interface uart_packet_tx_if #(
    parameter int N_BYTES = 20
);
    logic                   start;
    logic [8*N_BYTES-1:0]   payload;
    logic                   txd;
    logic                   busy;
    logic                   done;
    logic                   start_drop;
    logic                   baud_tick;

    modport master (
        output start, payload,
        input  txd, busy, done, start_drop, baud_tick
    );

    modport slave (
        input  start, payload,
        output txd, busy, done, start_drop, baud_tick
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Serialises one byte as 8N1/8N2 UART, each bit held for OVERSAMPLE baud ticks.
// Latency: start bit begins on the first baud_tick after acceptance.
// Backpressure: byte_ready is high only in IDLE; byte_done pulses on the final stop tick.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       txd
);

    localparam logic [5:0] BIT_TICKS  = 6'(OVERSAMPLE);
    localparam logic [5:0] STOP_TICKS = 6'(OVERSAMPLE * STOP_BITS);

    tx_state_t  state, state_nxt;
    logic [5:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       started;
    logic       txd_q;

    // tick_cnt counts the tick that opened the current bit as 1; the tick seen
    // at count BIT_TICKS opens the next bit.  The stop bit hands back on its
    // last counted tick so a queued byte can start on the very next tick.
    logic bit_last;
    logic stop_last;
    assign bit_last  = baud_tick && (tick_cnt == BIT_TICKS);
    assign stop_last = baud_tick && (tick_cnt == STOP_TICKS - 6'd1);

    // State register
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_nxt;
    end

    // Next state and ready
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        case (state)
            TX_IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = TX_START;
            end
            TX_START: if (started && bit_last)           state_nxt = TX_DATA;
            TX_DATA:  if (bit_last && bit_idx == 3'd7)   state_nxt = TX_STOP;
            TX_STOP:  if (stop_last)                     state_nxt = TX_IDLE;
            default:                                     state_nxt = TX_IDLE;
        endcase
    end

    // Bit timing, shift register and line driver
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= 6'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            started   <= 1'b0;
            txd_q     <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (byte_valid) begin
                        shreg   <= byte_data;
                        started <= 1'b0;
                    end
                end
                TX_START: begin
                    if (baud_tick) begin
                        if (!started) begin
                            started  <= 1'b1;
                            txd_q    <= 1'b0;
                            tick_cnt <= 6'd1;
                        end else if (tick_cnt == BIT_TICKS) begin
                            txd_q    <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_idx  <= 3'd0;
                            tick_cnt <= 6'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt == BIT_TICKS) begin
                            tick_cnt <= 6'd1;
                            if (bit_idx == 3'd7) begin
                                txd_q <= 1'b1;
                            end else begin
                                txd_q   <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt == STOP_TICKS - 6'd1) byte_done <= 1'b1;
                        else                               tick_cnt  <= tick_cnt + 6'd1;
                    end
                end
                default: txd_q <= 1'b1;
            endcase
        end
    end

    assign txd = txd_q;

endmodule

// File: rtl/uart_packet_tx.sv
// UART packet transmitter: header, latched payload, optional additive checksum.
// Latency: busy the cycle after start; first start bit on the next baud_tick after the first byte handoff.
// Backpressure: none upstream; starts while busy are ignored and flagged on start_drop.
module uart_packet_tx
    import uart_pkg::*;
#(
    parameter int          N_BYTES    = 20,
    parameter int          HDR_BYTES  = 2,
    parameter logic [31:0] HDR_VALUE  = 32'h00005A5A,
    parameter int          CHK_EN     = 1,
    parameter int          LSB_FIRST  = 0,
    parameter int          STOP_BITS  = 1,
    parameter logic [31:0] DEVIDE_CNT = 32'd13194140
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    uart_packet_tx_if.slave bus
);

    localparam int PW = 8 * N_BYTES;
    // Header left-aligned so the next byte to send is always hdr_sh[31:24].
    localparam logic [31:0] HDR_ALIGNED = (HDR_BYTES == 0) ? 32'd0 : (HDR_VALUE << (8 * (4 - HDR_BYTES)));
    localparam logic [6:0]  HDR_LAST    = 7'(HDR_BYTES - 1);
    localparam logic [6:0]  PAY_LAST    = 7'(N_BYTES - 1);

    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        baud_tick;

    pkt_state_t  state, state_nxt;
    logic [PW-1:0] pay_sh;
    logic [31:0] hdr_sh;
    logic [7:0]  chk;
    logic [6:0]  idx;
    logic        busy_q, done_q, drop_q;
    logic        byte_valid, byte_ready, byte_done, xfer, txd_w;
    logic [7:0]  byte_data, pay_byte;

    assign acc_sum  = {1'b0, acc} + {1'b0, DEVIDE_CNT};
    assign pay_byte = (LSB_FIRST != 0) ? pay_sh[7:0] : pay_sh[PW-1 -: 8];
    assign xfer     = byte_valid & byte_ready;

    // Free-running phase accumulator; its carry is the 16x baud enable
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 32'd0;
            baud_tick <= 1'b0;
        end else begin
            acc       <= acc_sum[31:0];
            baud_tick <= acc_sum[32];
        end
    end

    // Packet state register
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= PKT_IDLE;
        else        state <= state_nxt;
    end

    // Packet sequencing and byte presented to the serialiser
    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        case (state)
            PKT_IDLE: if (bus.start) state_nxt = (HDR_BYTES == 0) ? PKT_PAY : PKT_HDR;
            PKT_HDR: begin
                byte_valid = 1'b1;
                byte_data  = hdr_sh[31:24];
                if (xfer && idx == HDR_LAST) state_nxt = PKT_PAY;
            end
            PKT_PAY: begin
                byte_valid = 1'b1;
                byte_data  = pay_byte;
                if (xfer && idx == PAY_LAST) state_nxt = (CHK_EN != 0) ? PKT_CHK : PKT_FIN;
            end
            PKT_CHK: begin
                byte_valid = 1'b1;
                byte_data  = chk;
                if (xfer) state_nxt = PKT_FIN;
            end
            PKT_FIN: if (byte_done) state_nxt = PKT_IDLE;
            default: state_nxt = PKT_IDLE;
        endcase
    end

    // Payload/header shifters, checksum, status flags
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            pay_sh <= '0;
            hdr_sh <= 32'd0;
            chk    <= 8'h00;
            idx    <= 7'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= bus.start & busy_q;
            case (state)
                PKT_IDLE: begin
                    if (bus.start) begin
                        pay_sh <= bus.payload;
                        hdr_sh <= HDR_ALIGNED;
                        chk    <= 8'h00;
                        idx    <= 7'd0;
                        busy_q <= 1'b1;
                    end
                end
                PKT_HDR: begin
                    if (xfer) begin
                        hdr_sh <= hdr_sh << 8;
                        idx    <= (idx == HDR_LAST) ? 7'd0 : idx + 7'd1;
                    end
                end
                PKT_PAY: begin
                    if (xfer) begin
                        chk    <= chk + pay_byte;
                        pay_sh <= (LSB_FIRST != 0) ? (pay_sh >> 8) : (pay_sh << 8);
                        idx    <= idx + 7'd1;
                    end
                end
                PKT_FIN: begin
                    if (byte_done) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_byte_tx #(
        .STOP_BITS (STOP_BITS)
    ) u_byte_tx (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .txd        (txd_w)
    );

    assign bus.txd        = txd_w;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.start_drop = drop_q;
    assign bus.baud_tick  = baud_tick;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: three parameter sets share one clock/reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_packet_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_packet_tx_if #(.N_BYTES(4)) ifa ();
    uart_packet_tx_if #(.N_BYTES(4)) ifb ();
    uart_packet_tx_if #(.N_BYTES(4)) ifc ();

    uart_packet_tx #(.N_BYTES(4), .DEVIDE_CNT(32'h80000000)) u_a (
        .clk_50m(clk), .rst_n(rst_n), .bus(ifa));
    uart_packet_tx #(.N_BYTES(4), .HDR_BYTES(0), .CHK_EN(0), .LSB_FIRST(1),
                     .DEVIDE_CNT(32'h80000000)) u_b (
        .clk_50m(clk), .rst_n(rst_n), .bus(ifb));
    uart_packet_tx #(.N_BYTES(4), .STOP_BITS(2), .DEVIDE_CNT(32'h80000000)) u_c (
        .clk_50m(clk), .rst_n(rst_n), .bus(ifc));

    int   sel = 0;
    int   mon_stop = 1;
    logic mon_txd, mon_done, mon_busy, mon_drop;

    always_comb begin
        mon_txd = ifa.txd; mon_done = ifa.done; mon_busy = ifa.busy; mon_drop = ifa.start_drop;
        if (sel == 1) begin
            mon_txd = ifb.txd; mon_done = ifb.done; mon_busy = ifb.busy; mon_drop = ifb.start_drop;
        end else if (sel == 2) begin
            mon_txd = ifc.txd; mon_done = ifc.done; mon_busy = ifc.busy; mon_drop = ifc.start_drop;
        end
    end

    logic [7:0] byte_q[$];
    int         tstart_q[$];
    bit         ok_q[$];
    logic [7:0] exp_q[$];

    // Line decoder: samples mid-bit (32 clocks per bit) on the selected DUT
    initial begin : decoder
        logic [7:0] b;
        int         t0;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_txd === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (16) @(negedge clk);
                if (mon_txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (32) @(negedge clk);
                    b[i] = mon_txd;
                end
                for (int s = 0; s < mon_stop; s++) begin
                    repeat (32) @(negedge clk);
                    if (mon_txd !== 1'b1) ok = 1'b0;
                end
                byte_q.push_back(b);
                tstart_q.push_back(t0);
                ok_q.push_back(ok);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        byte_q.delete(); tstart_q.delete(); ok_q.delete();
    endtask

    task automatic count_done(input int n, output int nd, output int nbad,
                              output int ndrop, output int last_cyc);
        logic pb;
        nd = 0; nbad = 0; ndrop = 0; last_cyc = -1;
        pb = mon_busy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mon_done === 1'b1) begin
                nd++;
                last_cyc = cyc;
                if (!(mon_busy === 1'b0 && pb === 1'b1)) nbad++;
            end
            if (mon_drop === 1'b1) ndrop++;
            pb = mon_busy;
        end
    endtask

    task automatic check_frames(input string tag, input int spacing);
        chk($sformatf("%s_count", tag), byte_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, byte_q[i]}, {24'd0, exp_q[i]});
            chk($sformatf("%s_frame%0d", tag, i), {31'd0, ok_q[i]}, 32'd1);
            if (spacing > 0 && i > 0)
                chk($sformatf("%s_gap%0d", tag, i), tstart_q[i] - tstart_q[i-1], spacing);
        end
    endtask

    initial begin : stim
        int nd, nbad, ndrop, last_cyc, bt_bad, bt_ones, idle_bad, d;
        bit found;

        rst_n = 1'b0;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        ifa.payload = '0; ifb.payload = '0; ifc.payload = '0;

        chk("pkg_devide_9600", calc_devide_cnt(64'd50_000_000, 64'd9600), 32'd13194140);

        // 1. Reset
        repeat (5) @(negedge clk);
        chk("rst_txd", ifa.txd, 1);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_drop", ifa.start_drop, 0);
        chk("rst_tick", ifa.baud_tick, 0);
        rst_n = 1'b1;
        bt_bad = 0; bt_ones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.baud_tick !== 1'(i % 2)) bt_bad++;
            if (ifa.baud_tick === 1'b1) bt_ones++;
        end
        chk("tick_pattern", bt_bad, 0);
        chk("tick_count", bt_ones, 10);
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifa.txd !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.start_drop !== 1'b0)
                idle_bad++;
        end
        chk("idle_outputs", idle_bad, 0);

        // 2. Default packet, 4-byte payload
        sel = 0; clear_q();
        ifa.payload = 32'h01020304;
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        chk("t2_busy", ifa.busy, 1);
        count_done(3000, nd, nbad, ndrop, last_cyc);
        chk("t2_done_cnt", nd, 1);
        chk("t2_busy_fall", nbad, 0);
        exp_q = '{8'h5A, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        check_frames("t2", 320);
        d = (tstart_q.size() > 0) ? last_cyc - tstart_q[0] : -1;
        chk("t2_len", (d >= 2238 && d <= 2240), 1);

        // 3. LSB-first, no header, no checksum
        sel = 1; clear_q();
        ifb.payload = 32'hAABBCCDD;
        ifb.start = 1'b1; @(negedge clk); ifb.start = 1'b0;
        count_done(1600, nd, nbad, ndrop, last_cyc);
        chk("t3_done_cnt", nd, 1);
        exp_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        check_frames("t3", 320);

        // 4. Checksum wrap, two stop bits
        sel = 2; mon_stop = 2; clear_q();
        ifc.payload = 32'hFFFFFF03;
        ifc.start = 1'b1; @(negedge clk); ifc.start = 1'b0;
        count_done(3000, nd, nbad, ndrop, last_cyc);
        chk("t4_done_cnt", nd, 1);
        exp_q = '{8'h5A, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00};
        check_frames("t4", 352);
        mon_stop = 1;

        // 5. Start while busy, payload change, start on done
        sel = 0; clear_q();
        ifa.payload = 32'h11223344;
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        repeat (500) @(negedge clk);
        ifa.payload = 32'hDEADBEEF;
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        chk("t5_drop", ifa.start_drop, 1);
        @(negedge clk);
        chk("t5_drop_1cyc", ifa.start_drop, 0);
        found = 1'b0; ndrop = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (ifa.start_drop === 1'b1) ndrop++;
            if (ifa.done === 1'b1) found = 1'b1;
        end
        chk("t5_done_seen", found, 1);
        chk("t5_no_more_drops", ndrop, 0);
        ifa.payload = 32'h0A0B0C0D;
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        chk("t5_start_on_done_drop", ifa.start_drop, 0);
        chk("t5_start_on_done_busy", ifa.busy, 1);
        count_done(3000, nd, nbad, ndrop, last_cyc);
        chk("t5_done_cnt2", nd, 1);
        chk("t5_drop_cnt2", ndrop, 0);
        exp_q = '{8'h5A, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA,
                  8'h5A, 8'h5A, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h2E};
        check_frames("t5", 0);

        // 6. Reset during DATA of payload byte 2
        sel = 0; clear_q();
        ifa.payload = 32'h12345678;
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        for (int i = 0; i < 3000 && byte_q.size() < 3; i++) @(negedge clk);
        chk("t6_reached", (byte_q.size() >= 3), 1);
        repeat (100) @(negedge clk);
        chk("t6_txd_low", ifa.txd, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_txd_async", ifa.txd, 1);
        chk("t6_busy_async", ifa.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_done(400, nd, nbad, ndrop, last_cyc);
        chk("t6_no_done", nd, 0);
        clear_q();
        ifa.start = 1'b1; @(negedge clk); ifa.start = 1'b0;
        count_done(3000, nd, nbad, ndrop, last_cyc);
        chk("t6_done_cnt", nd, 1);
        exp_q = '{8'h5A, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
        check_frames("t6", 320);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
